vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch, pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width, pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch, pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch, lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width, lines.
REQ-008 Parameter V_BP, default 33, vertical back porch, lines.
REQ-009 Parameter SYNC_POL, default 0, active level of hsync/vsync (0 = active-low).
REQ-010 clk_in  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-011 reset  input  1  asynchronous, active-high reset.
REQ-012 pix_ce  input  1  pixel clock enable from the pixel clock divider; one advance per clk_in cycle with pix_ce=1.
REQ-013 enable  input  1  run/hold control; 0 freezes timing.
REQ-014 hsync  output  1  horizontal sync, registered.
REQ-015 vsync  output  1  vertical sync, registered.
REQ-016 de  output  1  display enable (active video), registered.
REQ-017 x  output  10  current horizontal count h_cnt.
REQ-018 y  output  10  current vertical count v_cnt.
REQ-019 line_start  output  1  one-clk_in-cycle pulse when h_cnt becomes 0.
REQ-020 frame_start  output  1  one-clk_in-cycle pulse when (h_cnt,v_cnt) becomes (0,0).

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both SHALL be <= 1024 (elaboration error otherwise).
REQ-022 An advancing edge is a clk_in rising edge with reset=0, pix_ce=1, enable=1; no other edge changes h_cnt or v_cnt.
REQ-023 On an advancing edge: h_cnt <= h_cnt+1; at H_TOTAL-1, h_cnt <= 0 and v_cnt advances.
REQ-024 v_cnt advances only on h_cnt wrap: v_cnt <= v_cnt+1; at V_TOTAL-1, v_cnt <= 0.
REQ-025 All outputs are registers decoded from next-state counters, so after any edge they reflect the current (h_cnt,v_cnt) with zero added latency.
REQ-026 hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
REQ-027 vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL; vsync changes only together with h_cnt wrapping to 0.
REQ-028 de = 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-029 x = h_cnt, y = v_cnt at all times, including blanking.
REQ-030 line_start = 1 for exactly the clk_in cycle after an advancing edge that sets h_cnt to 0; else 0.
REQ-031 frame_start = 1 for exactly the clk_in cycle after an advancing edge that sets (h_cnt,v_cnt) to (0,0); line_start is also 1 in that cycle.
REQ-032 Edges with pix_ce=0 or enable=0 hold counters, hsync, vsync, de, x, y and force line_start=frame_start=0.
REQ-033 pix_ce=1 continuously is legal; counters advance every clk_in cycle and pulses stay one cycle wide.
REQ-034 Consecutive pix_ce pulses of any spacing (including irregular) produce identical count sequences.

Reset
REQ-035 reset=1 immediately (asynchronously) sets h_cnt=H_TOTAL-1 (799), v_cnt=V_TOTAL-1 (524), hsync=vsync=~SYNC_POL, de=0, x=799, y=524, line_start=frame_start=0.
REQ-036 Reset takes priority over pix_ce and enable; the first advancing edge after release moves to (0,0) with de=1, line_start=1, frame_start=1.
REQ-037 Reset asserted mid-frame discards position; no partial-line pulse is emitted.

Verification
REQ-038 Assert reset -> x=799, y=524, de=0, hsync=1, vsync=1, pulses 0; release, one pix_ce -> x=0, y=0, de=1, line_start=frame_start=1 for one cycle.
REQ-039 pix_ce every 4th clk_in for one line -> de=1 for x 0..639 (640 pix_ce), hsync=0 for x 656..751 (96 pix_ce), one line_start per 800 pix_ce.
REQ-040 Full frame (420000 pix_ce) -> vsync=0 for y 490..491 (1600 pix_ce), exactly one frame_start, 480 lines with de activity.
REQ-041 enable=0 at (100,10) for 50 cycles with pix_ce toggling -> x=100, y=10, outputs frozen, no pulses; enable=1 -> next pix_ce gives x=101.
REQ-042 reset pulse at (300,200) mid-frame -> outputs return to REQ-035 values within the same cycle; next pix_ce -> (0,0) with frame_start=1.
REQ-043 pix_ce tied to 1 -> x increments each clk_in, wrap 799->0 increments y, 524/799 -> (0,0) with frame_start one cycle wide.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync, display-enable and line/frame pulses.
// Outputs are decoded from next-state counters, so they describe the current position with no added latency.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Thresholds kept one bit wider so an active width of 1024 still compares correctly
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       adv, h_wrap, v_wrap;

    always_comb begin
        adv           = pix_ce & enable;
        h_wrap        = h_cnt_q == H_LAST;
        v_wrap        = v_cnt_q == V_LAST;
        h_cnt_d       = !adv ? h_cnt_q : (h_wrap ? 10'd0 : h_cnt_q + 10'd1);
        v_cnt_d       = !(adv && h_wrap) ? v_cnt_q : (v_wrap ? 10'd0 : v_cnt_q + 10'd1);
        hsync_d       = ({1'b0, h_cnt_d} >= HS_FIRST && {1'b0, h_cnt_d} <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ({1'b0, v_cnt_d} >= VS_FIRST && {1'b0, v_cnt_d} <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        de_d          = {1'b0, h_cnt_d} < H_ACT && {1'b0, v_cnt_d} < V_ACT;
        line_start_d  = adv && h_wrap;
        frame_start_d = adv && h_wrap && v_wrap;
    end

    // Reset parks the raster on its last position so the first advance lands on (0,0)
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default-geometry and a small-geometry instance against a raster-position model.
module tb_vga_timing_gen;
    logic clk_in = 1'b0, reset = 1'b1, pix_ce = 1'b0, enable = 1'b1;
    logic a_hs, a_vs, a_de, a_ls, a_fs, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] a_x, a_y, b_x, b_y;
    int total = 0, fails = 0;
    int n = 0;
    logic adv_last = 1'b0;

    always #5 clk_in = ~clk_in;

    vga_timing_gen dut_a (
        .clk_in(clk_in), .reset(reset), .pix_ce(pix_ce), .enable(enable),
        .hsync(a_hs), .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dut_b (
        .clk_in(clk_in), .reset(reset), .pix_ce(pix_ce), .enable(enable),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic hs, vs, de, ls, fs;
    } exp_t;

    // Position is simply (advances since reset - 1) modulo the frame size
    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            n <= 0;
            adv_last <= 1'b0;
        end else begin
            adv_last <= pix_ce && enable;
            if (pix_ce && enable) n <= n + 1;
        end
    end

    function automatic exp_t model(input int cnt, input logic adv, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs, input int vb,
                                   input logic pol);
        exp_t e;
        int ht, vt, tot, p, xx, yy;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        tot = ht * vt;
        p = (cnt + tot - 1) % tot;
        xx = p % ht;
        yy = p / ht;
        e.x = 10'(xx);
        e.y = 10'(yy);
        e.hs = (xx >= ha + hf && xx < ha + hf + hs) ? pol : !pol;
        e.vs = (yy >= va + vf && yy < va + vf + vs) ? pol : !pol;
        e.de = xx < ha && yy < va;
        e.ls = adv && xx == 0;
        e.fs = adv && p == 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t ea, eb;
        ea = model(n, adv_last, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        eb = model(n, adv_last, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1);
        chk("a_x", a_x, ea.x);   chk("a_y", a_y, ea.y);
        chk("a_hsync", a_hs, ea.hs); chk("a_vsync", a_vs, ea.vs);
        chk("a_de", a_de, ea.de); chk("a_line_start", a_ls, ea.ls);
        chk("a_frame_start", a_fs, ea.fs);
        chk("b_x", b_x, eb.x);   chk("b_y", b_y, eb.y);
        chk("b_hsync", b_hs, eb.hs); chk("b_vsync", b_vs, eb.vs);
        chk("b_de", b_de, eb.de); chk("b_line_start", b_ls, eb.ls);
        chk("b_frame_start", b_fs, eb.fs);
    end

    task automatic cyc(input logic ce);
        pix_ce = ce;
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        int de_c, hs_c, ls_c, fs_c, vs_c, ln_c;
        repeat (3) cyc(1'b1);
        chk("rst_x", a_x, 799); chk("rst_y", a_y, 524); chk("rst_de", a_de, 0);
        chk("rst_hsync", a_hs, 1); chk("rst_vsync", a_vs, 1);
        chk("rst_ls", a_ls, 0); chk("rst_fs", a_fs, 0);
        reset = 1'b0;
        cyc(1'b0);
        chk("idle_x", a_x, 799);
        cyc(1'b1);
        chk("first_x", a_x, 0); chk("first_y", a_y, 0); chk("first_de", a_de, 1);
        chk("first_ls", a_ls, 1); chk("first_fs", a_fs, 1);
        cyc(1'b0);
        chk("pulse_end_ls", a_ls, 0); chk("pulse_end_fs", a_fs, 0);
        de_c = 0; hs_c = 0; ls_c = 0;
        for (int i = 0; i < 800; i++) begin
            cyc(1'b1);
            de_c += int'(a_de); hs_c += int'(!a_hs); ls_c += int'(a_ls);
            repeat (3) cyc(1'b0);
        end
        chk("line_de_count", de_c, 640); chk("line_hsync_count", hs_c, 96);
        chk("line_ls_count", ls_c, 1); chk("line_end_x", a_x, 0); chk("line_end_y", a_y, 1);
        repeat (7300) cyc(1'b1);
        chk("hold_pos_x", a_x, 100); chk("hold_pos_y", a_y, 10);
        enable = 1'b0;
        ls_c = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'(i % 2));
            ls_c += int'(a_ls) + int'(a_fs);
        end
        chk("hold_x", a_x, 100); chk("hold_y", a_y, 10); chk("hold_pulses", ls_c, 0);
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        chk("resume_x", a_x, 101);
        fs_c = 0; vs_c = 0; de_c = 0; ln_c = 0;
        for (int i = 0; i < 608; i++) begin
            cyc(1'b1);
            fs_c += int'(b_fs); vs_c += int'(b_vs); de_c += int'(b_de);
            ln_c += int'(b_de && b_x == 0);
            repeat (i % 4) cyc(1'b0);
        end
        chk("frame_fs_count", fs_c, 1); chk("frame_vsync_count", vs_c, 64);
        chk("frame_de_count", de_c, 192); chk("frame_de_lines", ln_c, 12);
        repeat (5) cyc(1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_x", a_x, 799); chk("mid_rst_y", a_y, 524); chk("mid_rst_de", a_de, 0);
        chk("mid_rst_hsync", a_hs, 1); chk("mid_rst_vsync", a_vs, 1);
        chk("mid_rst_ls", a_ls, 0); chk("b_mid_rst_x", b_x, 31); chk("b_mid_rst_y", b_y, 18);
        cyc(1'b1);
        reset = 1'b0;
        cyc(1'b1);
        chk("post_rst_x", a_x, 0); chk("post_rst_y", a_y, 0); chk("post_rst_de", a_de, 1);
        chk("post_rst_ls", a_ls, 1); chk("post_rst_fs", a_fs, 1);
        fs_c = 0;
        for (int i = 0; i < 1216; i++) begin
            cyc(1'b1);
            fs_c += int'(b_fs);
        end
        chk("cont_fs_count", fs_c, 2); chk("cont_b_x", b_x, 0); chk("cont_b_y", b_y, 0);
        cyc(1'b0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
